int_issue_queue: RTL and testbench
==================================

// Module: int_issue_queue
// PURPOSE
//  Integer-unit reservation station; sits on the consumer side of the common data bus (CDB).
//  Holds up to DEPTH dispatched integer ops and snoops each CDB broadcast for producer tags.
//  Captures operand values from the CDB and issues the lowest-index ready entry to the int ALU.
//  Its issue_int pulse feeds the CDB arbitration logic.
// PARAMETERS
//  DEPTH   4   number of entries, 2..8
//  TAG_W   6   width of a rename/ROB tag
//  DATA_W  32  operand/result width
//  OPC_W   4   ALU opcode width
// PORTS
//  clk              in   1       rising-edge clock
//  rst              in   1       asynchronous, active-high reset
//  flush            in   1       synchronous: invalidate all entries
//  dispatch_valid   in   1       dispatch request this cycle
//  dispatch_opcode  in   OPC_W   ALU opcode
//  dispatch_rd_tag  in   TAG_W   destination tag
//  dispatch_rsN_rdy in   1       N=1,2: operand value already valid
//  dispatch_rsN_tag in   TAG_W   N=1,2: producer tag when not ready
//  dispatch_rsN_val in   DATA_W  N=1,2: operand value when ready
//  iq_full          out  1       all entries valid; dispatch is not accepted
//  cdb_valid        in   1       CDB broadcast valid
//  cdb_tag          in   TAG_W   broadcast producer tag
//  cdb_data         in   DATA_W  broadcast result
//  ex_ready         in   1       int ALU can accept an op this cycle
//  issue_int        out  1       one-cycle pulse: op presented on issue_* outputs
//  issue_opcode     out  OPC_W   issued opcode
//  issue_rs1_data   out  DATA_W  issued operand 1
//  issue_rs2_data   out  DATA_W  issued operand 2
//  issue_rd_tag     out  TAG_W   issued destination tag
//  stall_cnt        out  16      present only with IQ_STALL_CNT_EN
// BEHAVIOUR
//  Reset: all entries invalid; issue_int=0, issue_* = 0, iq_full=0, stall_cnt=0.
//  Entry fields: valid, opcode, rd_tag, and per operand {rdy, tag, val}.
//  Allocation:
//   - dispatch_valid && !iq_full writes the lowest-index invalid entry at the clock edge.
//   - Dispatch while iq_full is dropped silently; the upstream stage must hold its request.
//  iq_full: combinational, equals AND of the entry valid bits as stored (pre-edge).
//   - A same-cycle issue does not free a slot for a same-cycle dispatch.
//  CDB snoop, every cycle:
//   - For each valid entry with rsN.rdy=0 and cdb_valid && cdb_tag==rsN.tag: set rdy=1, val=cdb_data.
//   - Both operands of one entry may capture from the same broadcast.
//  Dispatch bypass:
//   - When a dispatched operand has rdy=0, cdb_valid=1 and its tag == cdb_tag in the same cycle,
//     the entry is written with rdy=1 and val=cdb_data.
//  Issue select, combinational on stored state:
//   - Candidates are entries with valid && rs1.rdy && rs2.rdy; the lowest index wins.
//   - Operands captured at edge k are eligible for selection in cycle k+1; there is no same-cycle wakeup.
//  Issue, registered:
//   - If ex_ready and a candidate exists, then at the edge: issue_int<=1, issue_* <= entry fields,
//     and the entry's valid bit <= 0.
//   - Otherwise issue_int<=0 and issue_* hold their previous values.
//   - Latency: dispatch with both operands ready at edge k -> issue_int=1 after edge k+1 at the earliest.
//  flush:
//   - At the edge, all valid bits <= 0 and issue_int <= 0.
//   - Dispatch and issue in the flush cycle are discarded.
//   - flush has priority over every other action.
//  Reset mid-operation: asynchronous clear to the reset state, regardless of in-flight issue.
//  Tags are compared exactly (TAG_W bits). A CDB broadcast with no matching entry is ignored.
// CONFIGURATION
//  IQ_STALL_CNT_EN defined:
//   - stall_cnt port exists; increments by 1 on each cycle with dispatch_valid && iq_full.
//   - Saturates at 16'hFFFF; cleared by rst only (not by flush).
//  IQ_STALL_CNT_EN undefined: no stall_cnt port and no counter logic.
// TESTING
//  T1: reset -> iq_full=0, issue_int=0; dispatch add (rdy,rdy, rd_tag=5), ex_ready=1
//      -> issue_int=1 two edges later with rd_tag=5.
//  T2: dispatch rs1 tag=3 not ready; cdb_valid, tag=3, data=32'hDEAD two cycles later
//      -> captured; issue_rs1_data=32'hDEAD, issued on the second edge after capture.
//  T3: dispatch with rs2 tag=7 while the CDB broadcasts tag=7 in the same cycle
//      -> bypass capture; issues with no further broadcast.
//  T4: fill 4 entries with ex_ready=0 -> iq_full=1; 5th dispatch dropped;
//      ex_ready=1 -> entries issue in index order 0,1,2,3.
//  T5: 3 valid entries plus a flush with simultaneous dispatch
//      -> all invalid next cycle, issue_int=0, iq_full=0.
//  T6 (IQ_STALL_CNT_EN): hold dispatch_valid for 10 cycles while full -> stall_cnt=10;
//      flush leaves it at 10.

Source files
------------

// File: rtl/int_issue_queue.sv
// Integer reservation station: holds dispatched ops, snoops the CDB for operands, issues the lowest ready entry.
// Optional IQ_STALL_CNT_EN adds a saturating count of dispatch attempts rejected while full.
module int_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dispatch_valid,
  input  logic [OPC_W-1:0]  dispatch_opcode,
  input  logic [TAG_W-1:0]  dispatch_rd_tag,
  input  logic              dispatch_rs1_rdy,
  input  logic [TAG_W-1:0]  dispatch_rs1_tag,
  input  logic [DATA_W-1:0] dispatch_rs1_val,
  input  logic              dispatch_rs2_rdy,
  input  logic [TAG_W-1:0]  dispatch_rs2_tag,
  input  logic [DATA_W-1:0] dispatch_rs2_val,
  output logic              iq_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              ex_ready,
  output logic              issue_int,
  output logic [OPC_W-1:0]  issue_opcode,
  output logic [DATA_W-1:0] issue_rs1_data,
  output logic [DATA_W-1:0] issue_rs2_data,
  output logic [TAG_W-1:0]  issue_rd_tag
`ifdef IQ_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  rs1_rdy;
  logic [DEPTH-1:0]  rs2_rdy;
  logic [OPC_W-1:0]  opcode  [DEPTH];
  logic [TAG_W-1:0]  rd_tag  [DEPTH];
  logic [TAG_W-1:0]  rs1_tag [DEPTH];
  logic [TAG_W-1:0]  rs2_tag [DEPTH];
  logic [DATA_W-1:0] rs1_val [DEPTH];
  logic [DATA_W-1:0] rs2_val [DEPTH];

  logic             alloc_found;
  logic [IDX_W-1:0] alloc_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             do_dispatch;
  logic             do_issue;
  logic             d_rs1_rdy;
  logic             d_rs2_rdy;
  logic [DATA_W-1:0] d_rs1_val;
  logic [DATA_W-1:0] d_rs2_val;
  logic [DEPTH-1:0] snoop1;
  logic [DEPTH-1:0] snoop2;

  assign iq_full = &valid;

  // Descending scan so the last assignment leaves the lowest matching index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    alloc_found = 1'b0;
    alloc_idx   = '0;
    sel_found   = 1'b0;
    sel_idx     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
      if (valid[i] && rs1_rdy[i] && rs2_rdy[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    snoop1 = '0;
    snoop2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      snoop1[i] = valid[i] && !rs1_rdy[i] && cdb_valid && (cdb_tag == rs1_tag[i]);
      snoop2[i] = valid[i] && !rs2_rdy[i] && cdb_valid && (cdb_tag == rs2_tag[i]);
    end
  end

  // A not-ready dispatched operand may be satisfied by the broadcast in the same cycle.
  assign d_rs1_rdy = dispatch_rs1_rdy || (cdb_valid && (cdb_tag == dispatch_rs1_tag));
  assign d_rs2_rdy = dispatch_rs2_rdy || (cdb_valid && (cdb_tag == dispatch_rs2_tag));
  assign d_rs1_val = dispatch_rs1_rdy ? dispatch_rs1_val : cdb_data;
  assign d_rs2_val = dispatch_rs2_rdy ? dispatch_rs2_val : cdb_data;

  assign do_dispatch = dispatch_valid && !iq_full && alloc_found && !flush;
  assign do_issue    = ex_ready && sel_found && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid          <= '0;
      rs1_rdy        <= '0;
      rs2_rdy        <= '0;
      issue_int      <= 1'b0;
      issue_opcode   <= '0;
      issue_rs1_data <= '0;
      issue_rs2_data <= '0;
      issue_rd_tag   <= '0;
    end else if (flush) begin
      valid     <= '0;
      issue_int <= 1'b0;
    end else begin
      issue_int <= do_issue;
      for (int i = 0; i < DEPTH; i++) begin
        if (snoop1[i]) rs1_rdy[i] <= 1'b1;
        if (snoop2[i]) rs2_rdy[i] <= 1'b1;
      end
      // The allocated slot is invalid and the selected one valid, so these never collide.
      if (do_dispatch) begin
        valid[alloc_idx]   <= 1'b1;
        rs1_rdy[alloc_idx] <= d_rs1_rdy;
        rs2_rdy[alloc_idx] <= d_rs2_rdy;
      end
      if (do_issue) begin
        valid[sel_idx] <= 1'b0;
        issue_opcode   <= opcode[sel_idx];
        issue_rs1_data <= rs1_val[sel_idx];
        issue_rs2_data <= rs2_val[sel_idx];
        issue_rd_tag   <= rd_tag[sel_idx];
      end
    end
  end

  // NOTE: payload storage has no reset; it is only read when the entry's reset-cleared valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (snoop1[i]) rs1_val[i] <= cdb_data;
      if (snoop2[i]) rs2_val[i] <= cdb_data;
    end
    if (do_dispatch) begin
      opcode[alloc_idx]  <= dispatch_opcode;
      rd_tag[alloc_idx]  <= dispatch_rd_tag;
      rs1_tag[alloc_idx] <= dispatch_rs1_tag;
      rs2_tag[alloc_idx] <= dispatch_rs2_tag;
      rs1_val[alloc_idx] <= d_rs1_val;
      rs2_val[alloc_idx] <= d_rs2_val;
    end
  end

`ifdef IQ_STALL_CNT_EN
  // Survives flush on purpose: it measures upstream back-pressure over the whole run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (dispatch_valid && iq_full && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: reset, issue latency, CDB capture/bypass, full, flush, async reset.
// Define IQ_STALL_CNT_EN for both files to exercise the stall counter as well.
module tb_int_issue_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        dispatch_valid;
  logic [3:0]  dispatch_opcode;
  logic [5:0]  dispatch_rd_tag;
  logic        dispatch_rs1_rdy;
  logic [5:0]  dispatch_rs1_tag;
  logic [31:0] dispatch_rs1_val;
  logic        dispatch_rs2_rdy;
  logic [5:0]  dispatch_rs2_tag;
  logic [31:0] dispatch_rs2_val;
  logic        iq_full;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        ex_ready;
  logic        issue_int;
  logic [3:0]  issue_opcode;
  logic [31:0] issue_rs1_data;
  logic [31:0] issue_rs2_data;
  logic [5:0]  issue_rd_tag;
`ifdef IQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  int_issue_queue #(.DEPTH(4), .TAG_W(6), .DATA_W(32), .OPC_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .dispatch_valid   (dispatch_valid),
    .dispatch_opcode  (dispatch_opcode),
    .dispatch_rd_tag  (dispatch_rd_tag),
    .dispatch_rs1_rdy (dispatch_rs1_rdy),
    .dispatch_rs1_tag (dispatch_rs1_tag),
    .dispatch_rs1_val (dispatch_rs1_val),
    .dispatch_rs2_rdy (dispatch_rs2_rdy),
    .dispatch_rs2_tag (dispatch_rs2_tag),
    .dispatch_rs2_val (dispatch_rs2_val),
    .iq_full          (iq_full),
    .cdb_valid        (cdb_valid),
    .cdb_tag          (cdb_tag),
    .cdb_data         (cdb_data),
    .ex_ready         (ex_ready),
    .issue_int        (issue_int),
    .issue_opcode     (issue_opcode),
    .issue_rs1_data   (issue_rs1_data),
    .issue_rs2_data   (issue_rs2_data),
    .issue_rd_tag     (issue_rd_tag)
`ifdef IQ_STALL_CNT_EN
    ,
    .stall_cnt        (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush          = 1'b0;
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
  endtask

  task automatic disp(input logic [3:0] opc, input logic [5:0] rd,
                      input logic r1rdy, input logic [5:0] r1tag, input logic [31:0] r1val,
                      input logic r2rdy, input logic [5:0] r2tag, input logic [31:0] r2val);
    dispatch_valid   = 1'b1;
    dispatch_opcode  = opc;
    dispatch_rd_tag  = rd;
    dispatch_rs1_rdy = r1rdy;
    dispatch_rs1_tag = r1tag;
    dispatch_rs1_val = r1val;
    dispatch_rs2_rdy = r2rdy;
    dispatch_rs2_tag = r2tag;
    dispatch_rs2_val = r2val;
  endtask

  task automatic bcast(input logic [5:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    ex_ready = 1'b0;
    disp(4'd0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    dispatch_valid = 1'b0;
    cdb_tag  = 6'd0;
    cdb_data = 32'd0;
    #12;
    check("reset_iq_full", 64'(iq_full), 64'd0);
    check("reset_issue_int", 64'(issue_int), 64'd0);
    check("reset_rd_tag", 64'(issue_rd_tag), 64'd0);
    check("reset_rs1_data", 64'(issue_rs1_data), 64'd0);
`ifdef IQ_STALL_CNT_EN
    check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    rst = 1'b0;

    // T1: both operands ready -> issue_int one edge after the write edge.
    ex_ready = 1'b1;
    disp(4'd1, 6'd5, 1'b1, 6'd0, 32'd10, 1'b1, 6'd0, 32'd20);
    step();
    idle();
    check("t1_no_issue_at_write", 64'(issue_int), 64'd0);
    step();
    check("t1_issue_int", 64'(issue_int), 64'd1);
    check("t1_rd_tag", 64'(issue_rd_tag), 64'd5);
    check("t1_opcode", 64'(issue_opcode), 64'd1);
    check("t1_rs1", 64'(issue_rs1_data), 64'd10);
    check("t1_rs2", 64'(issue_rs2_data), 64'd20);
    step();
    check("t1_pulse_ends", 64'(issue_int), 64'd0);
    check("t1_rd_tag_held", 64'(issue_rd_tag), 64'd5);

    // T2: rs1 waits on tag 3; an unrelated broadcast is ignored, then tag 3 is captured.
    disp(4'd2, 6'd9, 1'b0, 6'd3, 32'd0, 1'b1, 6'd0, 32'd7);
    step();
    idle();
    bcast(6'd4, 32'h1234);
    step();
    check("t2_unrelated_cdb", 64'(issue_int), 64'd0);
    bcast(6'd3, 32'hDEAD);
    step();
    idle();
    check("t2_no_same_cycle_wakeup", 64'(issue_int), 64'd0);
    step();
    check("t2_issue_int", 64'(issue_int), 64'd1);
    check("t2_rs1_captured", 64'(issue_rs1_data), 64'hDEAD);
    check("t2_rs2", 64'(issue_rs2_data), 64'd7);
    check("t2_rd_tag", 64'(issue_rd_tag), 64'd9);

    // T3: rs2 tag 7 broadcast in the dispatch cycle -> bypass capture.
    disp(4'd3, 6'd11, 1'b1, 6'd0, 32'd100, 1'b0, 6'd7, 32'd0);
    bcast(6'd7, 32'd55);
    step();
    idle();
    step();
    check("t3_issue_int", 64'(issue_int), 64'd1);
    check("t3_rs2_bypass", 64'(issue_rs2_data), 64'd55);
    check("t3_rs1", 64'(issue_rs1_data), 64'd100);
    check("t3_rd_tag", 64'(issue_rd_tag), 64'd11);

    // T4: fill with ex_ready low; dispatches while full are dropped, even with a same-cycle issue.
    ex_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(4'd4, 6'(20 + i), 1'b1, 6'd0, 32'(i), 1'b1, 6'd0, 32'd0);
      step();
      if (i == 2) check("t4_not_full_at_3", 64'(iq_full), 64'd0);
    end
    check("t4_full", 64'(iq_full), 64'd1);
    disp(4'd4, 6'd24, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    step();
    check("t4_full_after_drop", 64'(iq_full), 64'd1);
    check("t4_no_issue_ex_low", 64'(issue_int), 64'd0);
    ex_ready = 1'b1;
    disp(4'd4, 6'd25, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    step();
    idle();
    check("t4_issue0_tag", 64'(issue_rd_tag), 64'd20);
    check("t4_issue0_int", 64'(issue_int), 64'd1);
    check("t4_slot_freed", 64'(iq_full), 64'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      check("t4_issue_order_tag", 64'(issue_rd_tag), 64'(20 + i));
      check("t4_issue_order_rs1", 64'(issue_rs1_data), 64'(i));
    end
    step();
    check("t4_dropped_not_issued", 64'(issue_int), 64'd0);

    // T5: three entries, then flush with simultaneous dispatch and a ready issuer.
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(4'd5, 6'(30 + i), 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
      step();
    end
    disp(4'd5, 6'd33, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    ex_ready = 1'b1;
    flush    = 1'b1;
    step();
    idle();
    check("t5_flush_issue_int", 64'(issue_int), 64'd0);
    check("t5_flush_iq_full", 64'(iq_full), 64'd0);
    check("t5_issue_fields_held", 64'(issue_rd_tag), 64'd23);
    step();
    check("t5_nothing_left", 64'(issue_int), 64'd0);

    // Asynchronous reset in the middle of a cycle with a full queue.
    ex_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(4'd6, 6'(40 + i), 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
      step();
    end
    idle();
    check("rst_pre_full", 64'(iq_full), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_full", 64'(iq_full), 64'd0);
    check("rst_async_rd_tag", 64'(issue_rd_tag), 64'd0);
    #1 rst = 1'b0;

`ifdef IQ_STALL_CNT_EN
    // T6: ten held dispatches while full count ten stalls; flush does not clear the count.
    for (int i = 0; i < 4; i++) begin
      disp(4'd7, 6'(50 + i), 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
      step();
    end
    check("t6_fill_no_stall", 64'(stall_cnt), 64'd0);
    disp(4'd7, 6'd60, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    for (int i = 0; i < 10; i++) step();
    idle();
    check("t6_stall_cnt", 64'(stall_cnt), 64'd10);
    flush = 1'b1;
    step();
    idle();
    check("t6_flush_keeps_cnt", 64'(stall_cnt), 64'd10);
    check("t6_flush_empties", 64'(iq_full), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
